regfile_bus_master: RTL and testbench
=====================================

# regfile_bus_master

Initiator for the FIR register-file port: converts burst read/write commands into the register file's `address` / `en_write` / shared tristate `data` bus protocol. It sits between the FIR control sequencer (coefficient load, sample fetch) and the 64×16 register file. It handles bus direction, the register file's one-cycle read latency, address wrap and read back-pressure, so clients see only valid/ready streams.

## Interface
- `ADDR_W`, 6, register-file address width (depth 2^ADDR_W)
- `DATA_W`, 16, data word width
- `RD_FIFO_DEPTH`, 4, read-return buffer entries (≥4 for full throughput)

- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake
- `cmd_write`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR_W  start address
- `cmd_len`  in  ADDR_W  beats − 1 (0 → 1 beat, 63 → 64 beats)
- `wr_valid` / `wr_ready`  in/out  1  write-data handshake
- `wr_data`  in  DATA_W  write beat
- `rd_valid` / `rd_ready`  out/in  1  read-data handshake
- `rd_data`  out  DATA_W  read beat
- `rd_last`  out  1  final beat of the read burst
- `busy`  out  1  command in progress (state ≠ IDLE)
- `rf_address`  out  ADDR_W  to register file `address`
- `rf_en_write`  out  1  to register file `en_write`
- `rf_data`  inout  DATA_W  shared bus; driven only while `rf_en_write`=1, else high-Z

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: `cmd_ready`=1. A `cmd_valid` handshake latches addr/len/dir and moves to WRITE or READ.
- WRITE:
  - `wr_ready`=1 while beats remain.
  - Each accepted beat is registered. Next cycle: `rf_en_write`=1, `rf_address`=current addr, `rf_data`=beat.
  - Address increments modulo 2^ADDR_W.
  - After the last beat's bus cycle, return to IDLE.
- READ:
  - `rf_en_write`=0 and the bus is released.
  - One address is issued per cycle while `fifo_count + in_flight < RD_FIFO_DEPTH`.
  - The register file registers data at the end of the issue cycle. The master captures `rf_data` at the end of the following cycle into the read FIFO.
  - `in_flight` counts issued-but-uncaptured addresses (0–2).
  - After the last issue, go to DRAIN.
- DRAIN: wait until in_flight = 0 and the FIFO has emptied through `rd_ready`, then go to IDLE.
- `rd_last` = 1 on the FIFO head entry that is the burst's final beat.
- Address wrap: 63 → 0 silently. `cmd_len` = 63 touches every location exactly once.
- `wr_valid` outside WRITE is ignored (`wr_ready`=0). A `cmd_valid` while busy is held off (`cmd_ready`=0).
- Reset at any point:
  - Abort the burst, flush the FIFO, clear in_flight.
  - The next cycle starts in IDLE. No further `rf_en_write` pulses from the aborted burst.

## Timing
- Reset values: `cmd_ready`=0 during reset, 1 in the first cycle after; `wr_ready`=0, `rd_valid`=0, `rd_last`=0, `busy`=0, `rf_en_write`=0, `rf_address`=0, `rf_data`=Z.
- Write latency: beat handshake at edge k → `rf_en_write`=1 during cycle k+1 → register file stores at edge k+1. Throughput 1 beat/cycle.
- Read latency: address issued in cycle t → data on bus in cycle t+1 → `rd_valid` in cycle t+2. With `rd_ready` held high, throughput is 1 beat/cycle.
- `cmd_ready` rises the cycle after the last write bus cycle, or the cycle after the last read handshake.
- Write→read and read→write need no turnaround cycle. The bus drive enable is the same flop as `rf_en_write`, so the master and register file never drive together.
- `rd_valid`/`rd_data` are stable while `rd_ready`=0 (AXI-style hold).

## Structure
- Shared package `fir_rf_pkg`: `ADDR_W`, `DATA_W`, `RF_DEPTH`, FSM state enum `rfm_state_t`.
- One sub-module: `rf_rd_fifo`, a synchronous FIFO of RD_FIFO_DEPTH × DATA_W plus a last bit, with count output and synchronous active-high reset.
- The tristate assignment of `rf_data` lives only in the top module.

## Test plan
- Write burst: addr 10, len 2, data 0x1111/0x2222/0x3333 → `rf_en_write` high 3 cycles at addrs 10, 11, 12; readback burst returns the same data with `rd_last` on 0x3333.
- Wrap: read addr 62, len 3 after preloading 62, 63, 0, 1 = 0xA0..0xA3 → `rf_address` sequence 62, 63, 0, 1; rd_data 0xA0..0xA3.
- Back-pressure: 16-beat read, `rd_ready` toggles 1/0 each cycle → all 16 words in order, none lost or duplicated; `rd_data` held during stalls; FIFO never overflows.
- Single beat: `cmd_len`=0 read of addr 5 → exactly one `rd_valid` with `rd_last`=1 at cycle issue+2; `cmd_ready` returns the cycle after the handshake.
- Reset mid-write after 2 of 5 beats → no `rf_en_write` after the reset cycle; addrs of beats 3–5 unchanged; all outputs at reset values; a new command is accepted the cycle after reset drops.
- Bus contention check: with random mixed commands, assert `rf_data` is never X and the master drives only when `rf_en_write`=1.

Source files
------------

// File: rtl/fir_rf_pkg.sv
// rtl/fir_rf_pkg.sv - shared widths and FSM encoding for the FIR register-file port
// Purpose: register-file geometry plus the bus-master state encoding, shared by
// the master and anything that needs to decode its state.
// Ports: none (package).
package fir_rf_pkg;

  localparam int ADDR_W        = 6;
  localparam int DATA_W        = 16;
  localparam int RF_DEPTH      = 1 << ADDR_W;
  localparam int RD_FIFO_DEPTH = 4;

  typedef logic [1:0] rfm_state_t;

  localparam rfm_state_t ST_IDLE  = 2'd0;
  localparam rfm_state_t ST_WRITE = 2'd1;
  localparam rfm_state_t ST_READ  = 2'd2;
  localparam rfm_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/rf_rd_fifo.sv
// rtl/rf_rd_fifo.sv - read-return FIFO (data plus last flag) with occupancy count
// Purpose: buffers words captured from the register-file bus until the client
// takes them; head is registered storage, so it holds steady while not popped.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   push/push_data/last   write side (push while full is dropped)
//   pop                   consume head (ignored while empty)
//   head_valid/data/last  current head entry
//   count                 number of stored entries
module rf_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         push_last,
  input  logic                         pop,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head_data,
  output logic                         head_last,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH:0]     store [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  assign do_push    = push && (count != CNT_W'(DEPTH));
  assign head_data  = store[rd_ptr][WIDTH-1:0];
  assign head_last  = store[rd_ptr][WIDTH];

  always_ff @(posedge clock) begin
    if (do_push) begin
      store[wr_ptr] <= {push_last, push_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/regfile_bus_master.sv
// rtl/regfile_bus_master.sv - burst command initiator for the FIR register-file port
// Purpose: turns read/write burst commands into register-file address/en_write
// cycles on a shared tristate data bus, hiding the one-cycle read latency and
// applying read back-pressure through a small return FIFO.
// Ports:
//   clock, reset                         rising-edge clock, synchronous active-high reset
//   cmd_valid/ready, cmd_write/addr/len  burst command (len = beats - 1)
//   wr_valid/ready, wr_data              write beats
//   rd_valid/ready, rd_data, rd_last     read beats, rd_last on the final one
//   busy                                 burst in progress
//   rf_address, rf_en_write, rf_data     register-file port (rf_data shared tristate)
module regfile_bus_master
  import fir_rf_pkg::*;
#(
  parameter int ADDR_W        = fir_rf_pkg::ADDR_W,
  parameter int DATA_W        = fir_rf_pkg::DATA_W,
  parameter int RD_FIFO_DEPTH = fir_rf_pkg::RD_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_address,
  output logic              rf_en_write,
  inout  wire  [DATA_W-1:0] rf_data
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  rfm_state_t        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] beats_left;
  logic              issue_done;
  logic [DATA_W-1:0] wr_data_q;
  // p0: an issued address is on rf_address this cycle; p1: its data is on the bus
  logic              p0;
  logic              p0_last;
  logic              p1;
  logic              p1_last;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W+1:0]  occupancy;
  logic              cmd_fire;
  logic              wr_fire;
  logic              rd_fire;
  logic              rd_pop;
  logic              last_beat;
  logic              drain_done;

  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign last_beat = (beats_left == '0);

  assign wr_ready  = (state == ST_WRITE) && !issue_done;
  assign wr_fire   = wr_valid && wr_ready;

  // Reserve a FIFO slot for every word still in the pipe, so a stalled client
  // can never cause a captured word to be dropped.
  assign occupancy = (CNT_W+2)'(fifo_count) + (CNT_W+2)'(p0) + (CNT_W+2)'(p1);
  assign rd_fire   = (state == ST_READ) && (occupancy < (CNT_W+2)'(RD_FIFO_DEPTH));

  assign rd_pop     = rd_valid && rd_ready;
  // Leave DRAIN on the edge that consumes the final word, not a cycle later.
  assign drain_done = !p0 && !p1 &&
                      ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && rd_pop));

  // The bus enable is rf_en_write itself, so there is no overlap with the
  // register file's own drive window when switching direction.
  assign rf_data = rf_en_write ? wr_data_q : {DATA_W{1'bz}};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      beats_left  <= '0;
      issue_done  <= 1'b0;
      rf_address  <= '0;
      rf_en_write <= 1'b0;
      wr_data_q   <= '0;
      p0          <= 1'b0;
      p0_last     <= 1'b0;
      p1          <= 1'b0;
      p1_last     <= 1'b0;
    end else begin
      rf_en_write <= wr_fire;
      p0          <= rd_fire;
      p0_last     <= rd_fire && last_beat;
      p1          <= p0;
      p1_last     <= p0_last;

      if (wr_fire) begin
        wr_data_q <= wr_data;
      end

      if (wr_fire || rd_fire) begin
        rf_address <= cur_addr;
        cur_addr   <= cur_addr + ADDR_W'(1);
        beats_left <= beats_left - ADDR_W'(1);
        if (last_beat) begin
          issue_done <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            cur_addr   <= cmd_addr;
            beats_left <= cmd_len;
            issue_done <= 1'b0;
            state      <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          // issue_done is seen during the last beat's bus cycle
          if (issue_done) begin
            state <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (rd_fire && last_beat) begin
            state <= ST_DRAIN;
          end
        end
        default: begin
          if (drain_done) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  rf_rd_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_rd_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (p1),
    .push_data  (rf_data),
    .push_last  (p1_last),
    .pop        (rd_pop),
    .head_valid (rd_valid),
    .head_data  (rd_data),
    .head_last  (rd_last),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_regfile_bus_master.sv
// tb/tb_regfile_bus_master.sv - directed self-checking bench for regfile_bus_master
module tb_regfile_bus_master;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_addr  = '0;
  logic [5:0]  cmd_len   = '0;
  logic        wr_valid  = 1'b0;
  logic [15:0] wr_data   = '0;
  logic        rd_ready  = 1'b1;
  logic        cmd_ready;
  logic        wr_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic [5:0]  rf_address;
  logic        rf_en_write;
  wire  [15:0] rf_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] mem [64];
  logic [15:0] rf_q = 16'h0;
  logic [15:0] exp_mem [64];

  logic [15:0] rq_data [$];
  logic        rq_last [$];
  logic [5:0]  wl_addr [$];
  logic [15:0] wl_data [$];
  int          wl_cyc  [$];

  logic        stall_seen = 1'b0;
  logic [15:0] stall_data = '0;

  always #5 clock = ~clock;

  regfile_bus_master dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .busy        (busy),
    .rf_address  (rf_address),
    .rf_en_write (rf_en_write),
    .rf_data     (rf_data)
  );

  // Register-file model: registered read, drives the bus only when not written.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rf_en_write) mem[rf_address] <= rf_data;
    rf_q <= mem[rf_address];
  end
  assign rf_data = rf_en_write ? 16'hzzzz : rf_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rf_en_write) begin
      wl_addr.push_back(rf_address);
      wl_data.push_back(rf_data);
      wl_cyc.push_back(cyc);
    end
    if (!reset) begin
      chk("bus_known", 32'($isunknown(rf_data)), 32'd0);
      if (stall_seen) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", 32'(rd_data), 32'(stall_data));
      end
      if (rd_valid && rd_ready) begin
        rq_data.push_back(rd_data);
        rq_last.push_back(rd_last);
      end
      stall_seen = rd_valid && !rd_ready;
      stall_data = rd_data;
    end else begin
      stall_seen = 1'b0;
    end
  end

  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [5:0] l);
    logic ok;
    ok = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (ok) begin @(posedge clock); #1; end
    cmd_valid = 1'b0;
    chk("cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_wr();
    logic ok;
    ok = 1'b0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clock);
      if (wr_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin @(posedge clock); #1; end
    chk("wr_accept", 32'(ok), 32'd1);
  endtask

  task automatic write_burst(input logic [5:0] a, input logic [5:0] l,
                             input logic [15:0] base, input logic [15:0] step);
    logic [5:0]  ad;
    logic [15:0] d;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 6'(i);
      d  = base + 16'(i) * step;
      wr_valid = 1'b1; wr_data = d;
      wait_wr();
      exp_mem[ad] = d;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clock);
      if (!busy && cmd_ready) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic start_read(input logic [5:0] a, input logic [5:0] l);
    rq_data.delete();
    rq_last.delete();
    send_cmd(1'b0, a, l);
  endtask

  task automatic finish_read(input logic [5:0] a, input logic [5:0] l,
                             input logic toggle, input string tag);
    int         n;
    logic [5:0] ad;
    n = int'(l) + 1;
    for (int j = 0; j < 400; j++) begin
      if (rq_data.size() >= n) break;
      @(posedge clock); #1;
      if (toggle) rd_ready = ~rd_ready;
    end
    rd_ready = 1'b1;
    wait_idle({tag, "_idle"});
    chk({tag, "_count"}, 32'(rq_data.size()), 32'(n));
    for (int i = 0; i < n && i < rq_data.size(); i++) begin
      ad = a + 6'(i);
      chk($sformatf("%s_data%0d", tag, i), 32'(rq_data[i]), 32'(exp_mem[ad]));
      chk($sformatf("%s_last%0d", tag, i), 32'(rq_last[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws;
    logic w;
    logic [5:0] ra, rl;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 16'hC000 + 16'(i);
      exp_mem[i] = 16'hC000 + 16'(i);
    end

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_en_write", 32'(rf_en_write), 32'd0);
    chk("rst_address", 32'(rf_address), 32'd0);
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write burst 10..12 and its timing
    ws = wl_addr.size();
    write_burst(6'd10, 6'd2, 16'h1111, 16'h1111);
    @(negedge clock);
    chk("wr_last_bus", 32'(rf_en_write), 32'd1);
    chk("wr_last_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clock);
    chk("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("wr_done_en", 32'(rf_en_write), 32'd0);
    chk("wr_log_n", 32'(wl_addr.size() - ws), 32'd3);
    if (wl_addr.size() >= ws + 3) begin
      chk("wr_a0", 32'(wl_addr[ws]),   32'd10);
      chk("wr_a1", 32'(wl_addr[ws+1]), 32'd11);
      chk("wr_a2", 32'(wl_addr[ws+2]), 32'd12);
      chk("wr_d0", 32'(wl_data[ws]),   32'h1111);
      chk("wr_d1", 32'(wl_data[ws+1]), 32'h2222);
      chk("wr_d2", 32'(wl_data[ws+2]), 32'h3333);
      chk("wr_back2back", 32'(wl_cyc[ws+2] - wl_cyc[ws]), 32'd2);
    end
    start_read(6'd10, 6'd2);
    finish_read(6'd10, 6'd2, 1'b0, "rb");

    // Address wrap, write and read
    ws = wl_addr.size();
    write_burst(6'd62, 6'd3, 16'h00A0, 16'h0001);
    wait_idle("wrap_wr_idle");
    if (wl_addr.size() >= ws + 4) begin
      chk("wrap_wa2", 32'(wl_addr[ws+2]), 32'd0);
      chk("wrap_wa3", 32'(wl_addr[ws+3]), 32'd1);
    end
    start_read(6'd62, 6'd3);
    @(negedge clock);
    @(negedge clock); chk("wrap_ra0", 32'(rf_address), 32'd62);
    @(negedge clock); chk("wrap_ra1", 32'(rf_address), 32'd63);
    @(negedge clock); chk("wrap_ra2", 32'(rf_address), 32'd0);
    @(negedge clock); chk("wrap_ra3", 32'(rf_address), 32'd1);
    finish_read(6'd62, 6'd3, 1'b0, "wrap");
    chk("wrap_hand_d2", 32'(exp_mem[0]), 32'h00A2);

    // Single-beat read with exact latency
    start_read(6'd5, 6'd0);
    @(negedge clock); chk("sb_v1", 32'(rd_valid), 32'd0);
    @(negedge clock); chk("sb_v2", 32'(rd_valid), 32'd0);
    chk("sb_addr", 32'(rf_address), 32'd5);
    @(negedge clock); chk("sb_v3", 32'(rd_valid), 32'd0);
    @(negedge clock);
    chk("sb_valid", 32'(rd_valid), 32'd1);
    chk("sb_last", 32'(rd_last), 32'd1);
    chk("sb_data", 32'(rd_data), 32'hC005);
    chk("sb_busy_ready", 32'(cmd_ready), 32'd0);
    @(negedge clock);
    chk("sb_ready_back", 32'(cmd_ready), 32'd1);
    chk("sb_one_only", 32'(rd_valid), 32'd0);
    finish_read(6'd5, 6'd0, 1'b0, "sb");

    // 16-beat read with rd_ready toggling
    start_read(6'd30, 6'd15);
    finish_read(6'd30, 6'd15, 1'b1, "bp");

    // Reset after 2 of 5 write beats
    ws = wl_addr.size();
    send_cmd(1'b1, 6'd20, 6'd4);
    wr_valid = 1'b1; wr_data = 16'h5001;
    wait_wr(); exp_mem[20] = 16'h5001;
    wr_data = 16'h5002;
    wait_wr(); exp_mem[21] = 16'h5002;
    wr_data = 16'h5003;
    reset = 1'b1;
    @(negedge clock);
    chk("mr_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
    chk("mr_beat2_bus", 32'(rf_en_write), 32'd1);
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    chk("mr_en_write", 32'(rf_en_write), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_wr_ready", 32'(wr_ready), 32'd0);
    chk("mr_rd_valid", 32'(rd_valid), 32'd0);
    chk("mr_rd_last", 32'(rd_last), 32'd0);
    chk("mr_address", 32'(rf_address), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    wr_valid = 1'b0;
    rq_data.delete();
    rq_last.delete();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd20; cmd_len = 6'd4;
    @(posedge clock); #1; cmd_valid = 1'b0;
    @(negedge clock);
    chk("mr_new_cmd", 32'(busy), 32'd1);
    finish_read(6'd20, 6'd4, 1'b0, "mr");
    chk("mr_wlog_n", 32'(wl_addr.size() - ws), 32'd2);
    if (wl_addr.size() >= ws + 2) begin
      chk("mr_wa0", 32'(wl_addr[ws]),   32'd20);
      chk("mr_wa1", 32'(wl_addr[ws+1]), 32'd21);
    end

    // Random mixed commands against the scoreboard
    for (int k = 0; k < 12; k++) begin
      w  = 1'($urandom_range(0, 1));
      ra = 6'($urandom_range(0, 63));
      rl = 6'($urandom_range(0, 7));
      if (w) begin
        write_burst(ra, rl, 16'($urandom), 16'($urandom));
      end else begin
        start_read(ra, rl);
        finish_read(ra, rl, 1'(k % 2), "rnd");
      end
    end
    wait_idle("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
